// File: rtl/jtframe_dial_pkg.sv
// Shared types and Gray-code step tables for the dial quadrature counter.
// Table index is {prv, cur}; a set bit marks a legal step in that direction.
package jtframe_dial_pkg;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_INC,
        ST_DEC,
        ST_ERR
    } step_t;

    // Forward: 00->01, 01->11, 11->10, 10->00
    localparam logic [15:0] QSTEP_FWD = 16'h4182;
    // Reverse: 01->00, 11->01, 10->11, 00->10
    localparam logic [15:0] QSTEP_REV = 16'h2814;

    function automatic step_t qstep(
        input logic [1:0] prv,
        input logic [1:0] cur
    );
        logic [3:0] idx;
        step_t      st;
        idx = {prv, cur};
        if (prv == cur)
            st = ST_NONE;
        else if (QSTEP_FWD[idx])
            st = ST_INC;
        else if (QSTEP_REV[idx])
            st = ST_DEC;
        else
            st = ST_ERR;
        return st;
    endfunction

endpackage

// File: rtl/jtframe_dial_axis.sv
// One quadrature axis: input synchroniser, Gray decoder and up/down counter.
// cnt is the value the counter takes at the coming edge, so it includes this cycle's step.
module jtframe_dial_axis
    import jtframe_dial_pkg::*;
#(
    parameter int CW   = 12,
    parameter int SYNC = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    quad,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          moved
);

    logic [1:0]    sync_q [SYNC];
    logic [1:0]    prv;
    logic [1:0]    cur;
    logic [CW-1:0] cnt_q;
    step_t         step;

    assign cur  = sync_q[SYNC-1];
    assign step = qstep(prv, cur);

    always_comb begin
        cnt   = cnt_q;
        moved = 1'b0;
        if (rst || clr) begin
            cnt = '0;
        end else begin
            case (step)
                ST_INC: begin
                    cnt   = cnt_q + CW'(1);
                    moved = 1'b1;
                end
                ST_DEC: begin
                    cnt   = cnt_q - CW'(1);
                    moved = 1'b1;
                end
                default: cnt = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++)
                sync_q[i] <= 2'b00;
            prv   <= 2'b00;
            cnt_q <= '0;
        end else begin
            sync_q[0] <= quad;
            for (int i = 1; i < SYNC; i++)
                sync_q[i] <= sync_q[i-1];
            // Illegal double-bit edges still advance prv
            prv   <= cur;
            cnt_q <= cnt;
        end
    end

endmodule

// File: rtl/jtframe_dial_counter.sv
// Two-axis dial position counter with uPD4701-style byte readout.
// A cs rising edge freezes both counts; dout serves bytes of the frozen copy.
module jtframe_dial_counter
    import jtframe_dial_pkg::*;
#(
    parameter int CW   = 12,
    parameter int SYNC = 2
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dial_x,
    input  logic [1:0] dial_y,
    input  logic       cnt_clr,
    input  logic       cs,
    input  logic       xn_y,
    input  logic       un_l,
    output logic [7:0] dout,
    output logic       cf,
    output logic       sf_x,
    output logic       sf_y
);

    logic [CW-1:0] cnt_x;
    logic [CW-1:0] cnt_y;
    logic [CW-1:0] snap_x;
    logic [CW-1:0] snap_y;
    logic [CW-1:0] snap_sel;
    logic          moved_x;
    logic          moved_y;
    logic          cs_l;
    logic          cs_rise;
    logic [15:0]   sext;
    logic [7:0]    dout_nxt;

    jtframe_dial_axis #(.CW(CW), .SYNC(SYNC)) u_x (
        .clk   (clk),
        .rst   (rst),
        .quad  (dial_x),
        .clr   (cnt_clr),
        .cnt   (cnt_x),
        .moved (moved_x)
    );

    jtframe_dial_axis #(.CW(CW), .SYNC(SYNC)) u_y (
        .clk   (clk),
        .rst   (rst),
        .quad  (dial_y),
        .clr   (cnt_clr),
        .cnt   (cnt_y),
        .moved (moved_y)
    );

    assign cs_rise  = cs & ~cs_l;
    assign snap_sel = xn_y ? snap_x : snap_y;
    assign sext     = 16'($signed(snap_sel));
    assign dout_nxt = un_l ? sext[15:8] : sext[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_l   <= 1'b0;
            snap_x <= '0;
            snap_y <= '0;
            cf     <= 1'b0;
            dout   <= 8'h00;
            sf_x   <= 1'b0;
            sf_y   <= 1'b0;
        end else begin
            cs_l <= cs;
            if (cs_rise) begin
                snap_x <= cnt_x;
                snap_y <= cnt_y;
            end
            // A step landing with the snapshot is already captured in it
            if (cs_rise)
                cf <= 1'b0;
            else if (moved_x || moved_y)
                cf <= 1'b1;
            dout <= dout_nxt;
            sf_x <= cnt_x[CW-1];
            sf_y <= cnt_y[CW-1];
        end
    end

endmodule

// File: tb/tb_jtframe_dial_counter.sv
// Bench for jtframe_dial_counter: directed scenarios plus random traffic,
// all checked each cycle against a position/arithmetic reference model.
module tb_jtframe_dial_counter;

    localparam int CW   = 12;
    localparam int SYNC = 2;
    localparam int MASK = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dial_x;
    logic [1:0] dial_y;
    logic       cnt_clr;
    logic       cs;
    logic       xn_y;
    logic       un_l;
    logic [7:0] dout;
    logic       cf;
    logic       sf_x;
    logic       sf_y;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int         m_x, m_y, m_sx, m_sy, m_dout;
    bit         m_cf, m_sfx, m_sfy, m_csl;
    logic [1:0] m_px, m_py;
    logic [1:0] hx[$];
    logic [1:0] hy[$];

    jtframe_dial_counter #(.CW(CW), .SYNC(SYNC)) dut (
        .clk     (clk),
        .rst     (rst),
        .dial_x  (dial_x),
        .dial_y  (dial_y),
        .cnt_clr (cnt_clr),
        .cs      (cs),
        .xn_y    (xn_y),
        .un_l    (un_l),
        .dout    (dout),
        .cf      (cf),
        .sf_x    (sf_x),
        .sf_y    (sf_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Position of a pair along the Gray cycle 00,01,11,10
    function automatic int gpos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gval(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int gstep(input logic [1:0] p, input logic [1:0] c);
        int d;
        d = (gpos(c) - gpos(p) + 4) % 4;
        if (d == 1) return 1;
        if (d == 3) return -1;
        return 0;
    endfunction

    function automatic int byte_of(input int v, input bit up);
        int s;
        s = (v >= (1 << (CW - 1))) ? v - (1 << CW) : v;
        return up ? ((s >>> 8) & 255) : (s & 255);
    endfunction

    task automatic model_edge();
        int  sx, sy, nx, ny;
        bit  mv, rise;
        if (rst) begin
            m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_dout = 0;
            m_cf = 0; m_sfx = 0; m_sfy = 0; m_csl = 0;
            m_px = 2'b00; m_py = 2'b00;
            hx.delete(); hy.delete();
            for (int i = 0; i < SYNC; i++) begin
                hx.push_back(2'b00);
                hy.push_back(2'b00);
            end
        end else begin
            sx = gstep(m_px, hx[SYNC-1]);
            sy = gstep(m_py, hy[SYNC-1]);
            m_px = hx[SYNC-1];
            m_py = hy[SYNC-1];
            hx.push_front(dial_x); void'(hx.pop_back());
            hy.push_front(dial_y); void'(hy.pop_back());
            m_dout = byte_of(xn_y ? m_sx : m_sy, un_l);
            if (cnt_clr) begin
                nx = 0; ny = 0; mv = 0;
            end else begin
                nx = (m_x + sx) & MASK;
                ny = (m_y + sy) & MASK;
                mv = (sx != 0) || (sy != 0);
            end
            rise  = cs && !m_csl;
            m_csl = cs;
            if (rise) begin
                m_sx = nx;
                m_sy = ny;
            end
            m_cf  = rise ? 1'b0 : (m_cf || mv);
            m_x   = nx;
            m_y   = ny;
            m_sfx = nx[CW-1];
            m_sfy = ny[CW-1];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("dout", dout, m_dout);
        check("cf", cf, m_cf);
        check("sf_x", sf_x, m_sfx);
        check("sf_y", sf_y, m_sfy);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic step_x(input int dir);
        dial_x = gval(gpos(dial_x) + dir + 4);
    endtask

    task automatic snap_read(input bit ax, input bit up);
        xn_y = ax; un_l = up; cs = 1'b1;
        tick();
        cs = 1'b0;
        tick();
    endtask

    initial begin
        int r;
        rst = 1'b1; dial_x = 2'b00; dial_y = 2'b00;
        cnt_clr = 1'b0; cs = 1'b0; xn_y = 1'b0; un_l = 1'b0;
        ticks(2);
        check("rst_dout", dout, 0);
        check("rst_cf", cf, 0);
        check("rst_sf", {sf_x, sf_y}, 0);
        rst = 1'b0;
        ticks(2);

        // forward Gray walk with latency probe on the first edge
        dial_x = 2'b01;
        ticks(2);
        check("lat_early", cf, 0);
        tick();
        check("lat_3clk", cf, 1);
        tick();
        dial_x = 2'b11; ticks(4);
        dial_x = 2'b10; ticks(4);
        dial_x = 2'b00; ticks(4);
        check("t1_cf", cf, 1);
        snap_read(1'b1, 1'b0);
        check("t1_cnt", dout, 8'h04);

        // reverse 4 from zero
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step_x(-1); tick();
        end
        ticks(3);
        check("t2_sf", sf_x, 1);
        snap_read(1'b1, 1'b0);
        check("t2_lo", dout, 8'hFC);
        un_l = 1'b1; tick();
        check("t2_hi", dout, 8'hFF);
        check("t2_cf", cf, 0);

        // illegal edge on Y then a legal forward step
        dial_y = 2'b11; ticks(4);
        check("t3_ill_cf", cf, 0);
        dial_y = 2'b10; ticks(4);
        check("t3_cf", cf, 1);
        snap_read(1'b0, 1'b0);
        check("t3_y", dout, 8'h01);

        // wrap into negative range
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 2047; i++) begin
            step_x(1); tick();
        end
        ticks(3);
        check("t4_sf0", sf_x, 0);
        step_x(1); ticks(4);
        check("t4_sf1", sf_x, 1);
        snap_read(1'b1, 1'b1);
        check("t4_hi", dout, 8'hF8);

        // clear colliding with a committing step
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        snap_read(1'b1, 1'b0);
        step_x(1); ticks(2);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check("t5_clr_cf", cf, 0);
        snap_read(1'b1, 1'b0);
        check("t5_clr_cnt", dout, 0);
        // snapshot colliding with a committing step
        step_x(1); ticks(2);
        cs = 1'b1; tick();
        check("t5_cs_cf", cf, 0);
        cs = 1'b0; tick();
        check("t5_snap", dout, 8'h01);

        // cs held high: snapshot frozen while counting
        cs = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin
            step_x(1); tick();
        end
        ticks(3);
        check("t6_hold", dout, 8'h01);
        cs = 1'b0; tick();
        cs = 1'b1; tick(); tick();
        check("t6_new", dout, 8'h0B);
        step_x(1); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_rst_dout", dout, 0);
        check("t6_rst_flags", {cf, sf_x, sf_y}, 0);
        ticks(3);
        cs = 1'b0;

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3) step_x(1);
            else if (r < 5) step_x(-1);
            else if (r == 5) dial_x = dial_x ^ 2'b11;
            r = $urandom_range(0, 9);
            if (r < 3) dial_y = gval(gpos(dial_y) + 1);
            else if (r < 5) dial_y = gval(gpos(dial_y) + 3);
            else if (r == 5) dial_y = dial_y ^ 2'b11;
            if ($urandom_range(0, 3) == 0) cs = ~cs;
            cnt_clr = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            xn_y    = 1'($urandom_range(0, 1));
            un_l    = 1'($urandom_range(0, 1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
